// File: rtl/inst_fetch.sv
// inst_fetch: PC-driven instruction fetch with prefetch FIFO and redirect; IFETCH_HALT_EN enables halt on 16'hE000
module inst_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [15:0]            imem_addr,
  input  logic [15:0]            imem_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_instr,
  output logic [15:0]            out_pc,
  input  logic                   redirect_valid,
  input  logic [15:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   halted
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]   pc;
  logic [15:0]   mi [DEPTH];
  logic [15:0]   mp [DEPTH];
  logic [AW-1:0] hd, tl, hn;
  logic [AW:0]   rem;
  logic          pop, push, popc, hit;
  assign imem_addr = pc;
  assign out_valid = occupancy != '0;
  assign pop  = out_valid & out_ready;
  assign push = !redirect_valid & !halted & ((occupancy != (AW+1)'(DEPTH)) | pop);
  assign popc = pop & !redirect_valid;
  assign hn   = hd + AW'(popc);
  assign rem  = occupancy - (AW+1)'(popc);
`ifdef IFETCH_HALT_EN
  assign hit = push & (imem_instr == 16'hE000);
  // halt latches on pushing the self-branch word; only redirect or reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted <= 1'b0;
    else halted <= redirect_valid ? 1'b0 : (hit | halted);
  end
`else
  assign hit    = 1'b0;
  assign halted = 1'b0;
`endif
  // fifo storage: word and the pc it was fetched from
  always_ff @(posedge clk) begin
    if (push) begin
      mi[tl] <= imem_instr;
      mp[tl] <= pc;
    end
  end
  // pc, pointers, occupancy, and registered head entry (bypasses the word pushed into an empty fifo)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      hd        <= '0;
      tl        <= '0;
      occupancy <= '0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      pc        <= redirect_valid ? {redirect_pc[15:2], 2'b00} : (push & !hit) ? pc + 16'(PC_STEP) : pc;
      hd        <= redirect_valid ? '0 : hn;
      tl        <= redirect_valid ? '0 : tl + AW'(push);
      occupancy <= redirect_valid ? '0 : rem + (AW+1)'(push);
      if (!redirect_valid & ((rem != '0) | push)) begin
        out_instr <= (rem == '0) ? imem_instr : mi[hn];
        out_pc    <= (rem == '0) ? pc : mp[hn];
      end
    end
  end
endmodule
